// File: rtl/dmem_lsu_if.sv
// Request, memory-port and response signals of the data-memory load/store unit.
// The master modport is the LSU; the slave modport is the core/memory side.
interface dmem_lsu_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int ID_WIDTH      = 4
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [32:0]              req_wdata;
   logic [ID_WIDTH-1:0]      req_id;

   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [32:0]              mem_wdata;
   logic [32:0]              mem_rdata;

   logic                     resp_valid;
   logic                     resp_ready;
   logic                     resp_is_store;
   logic [32:0]              resp_rdata;
   logic [ID_WIDTH-1:0]      resp_id;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_id,
      output req_ready,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output resp_valid, resp_is_store, resp_rdata, resp_id,
      input  resp_ready
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_id,
      input  req_ready,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  resp_valid, resp_is_store, resp_rdata, resp_id,
      output resp_ready
   );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store requester for the single-port 33-bit data memory; responses appear one cycle after acceptance.
// A 2-entry response buffer absorbs resp_ready stalls; req_ready depends on registered occupancy only.
module dmem_lsu #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int ID_WIDTH      = 4
) (
   input logic        clk,
   input logic        rst,
   dmem_lsu_if.master bus
);
   typedef struct packed {
      logic                is_store;
      logic [32:0]         rdata;
      logic [ID_WIDTH-1:0] id;
   } resp_t;

   logic                inflight_vld_q, inflight_vld_d;
   logic                inflight_st_q, inflight_st_d;
   logic [ID_WIDTH-1:0] inflight_id_q, inflight_id_d;

   resp_t               fifo_q [2];
   logic [1:0]          cnt_q, cnt_d;
   logic                wptr_q, wptr_d;
   logic                rptr_q, rptr_d;

   logic                accept;
   logic                fifo_empty;
   logic                bypass;
   logic                push;
   logic                pop;
   logic                out_vld;
   resp_t               inflight_ent;
   resp_t               out_ent;
   logic [ADDRESS_WIDTH-1:0] issue_addr;

   // Occupancy counts the in-flight slot, so at most two responses are ever outstanding.
   assign bus.req_ready = !rst && (({1'b0, cnt_q} + {2'b00, inflight_vld_q}) <= 3'd1);
   assign accept        = bus.req_valid & bus.req_ready;

   assign issue_addr    = bus.req_addr;
   assign bus.mem_addr  = issue_addr;
   assign bus.mem_wdata = bus.req_wdata;
   assign bus.mem_we    = accept & bus.req_we;

   always_comb begin
      inflight_ent          = '0;
      inflight_ent.is_store = inflight_st_q;
      inflight_ent.rdata    = inflight_st_q ? 33'd0 : bus.mem_rdata;
      inflight_ent.id       = inflight_id_q;
   end

   assign fifo_empty = (cnt_q == 2'd0);
   assign bypass     = fifo_empty & inflight_vld_q;

   // Buffered entries always win so responses stay in acceptance order.
   always_comb begin
      out_ent = '0;
      out_vld = 1'b0;
      if (!rst) begin
         if (!fifo_empty) begin
            out_ent = fifo_q[rptr_q];
            out_vld = 1'b1;
         end else if (inflight_vld_q) begin
            out_ent = inflight_ent;
            out_vld = 1'b1;
         end
      end
   end

   assign bus.resp_valid    = out_vld;
   assign bus.resp_is_store = out_ent.is_store;
   assign bus.resp_rdata    = out_ent.rdata;
   assign bus.resp_id       = out_ent.id;

   // An unconsumed bypass is captured so later mem_rdata changes cannot disturb it.
   assign pop  = out_vld & !fifo_empty & bus.resp_ready;
   assign push = inflight_vld_q & !(bypass & bus.resp_ready);

   always_comb begin
      inflight_vld_d = accept;
      inflight_st_d  = accept ? bus.req_we : inflight_st_q;
      inflight_id_d  = accept ? bus.req_id : inflight_id_q;
      wptr_d         = push ? ~wptr_q : wptr_q;
      rptr_d         = pop ? ~rptr_q : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_vld_q <= 1'b0;
         inflight_st_q  <= 1'b0;
         inflight_id_q  <= '0;
         cnt_q          <= 2'd0;
         wptr_q         <= 1'b0;
         rptr_q         <= 1'b0;
         fifo_q[0]      <= '0;
         fifo_q[1]      <= '0;
      end else begin
         inflight_vld_q <= inflight_vld_d;
         inflight_st_q  <= inflight_st_d;
         inflight_id_q  <= inflight_id_d;
         cnt_q          <= cnt_d;
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         if (push) begin
            fifo_q[wptr_q] <= inflight_ent;
         end
      end
   end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed and random load/store streams checked against an in-order
// response queue fed from a shadow copy of memory.
module tb_dmem_lsu;
   logic clk;
   logic rst;
   logic mem_init;
   int   tests;
   int   fails;

   dmem_lsu_if #(.ADDRESS_WIDTH(8), .ID_WIDTH(4)) bus ();

   dmem_lsu #(.ADDRESS_WIDTH(8), .ID_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        st;
      logic [32:0] dat;
      logic [3:0]  id;
   } exp_t;

   exp_t        exp_q [$];
   logic [32:0] refmem [256];
   logic [32:0] mem [256];

   function automatic logic [32:0] pat(input int a);
      pat = {a[0], 16'hC0DE, 8'h5A, a[7:0]};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port synchronous memory: read data registered one cycle after the address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check after settling, update the model at the rising edge.
   task automatic step(input logic r, input logic v, input logic we, input logic [7:0] a,
                       input logic [32:0] d, input logic [3:0] id, input logic rd,
                       output logic acc);
      logic exp_rdy;
      exp_t h;
      rst            = r;
      bus.req_valid  = v;
      bus.req_we     = we;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_id     = id;
      bus.resp_ready = rd;
      #1;
      exp_rdy = !r && (exp_q.size() <= 1);
      check("req_ready", 40'(bus.req_ready), 40'(exp_rdy));
      check("mem_we", 40'(bus.mem_we), 40'(v & exp_rdy & we));
      check("mem_addr", 40'(bus.mem_addr), 40'(a));
      check("mem_wdata", 40'(bus.mem_wdata), 40'(d));
      if (r) begin
         check("rst_resp_valid", 40'(bus.resp_valid), 40'(0));
         check("rst_resp_rdata", 40'(bus.resp_rdata), 40'(0));
         check("rst_resp_id", 40'(bus.resp_id), 40'(0));
         check("rst_resp_is_store", 40'(bus.resp_is_store), 40'(0));
      end else begin
         check("resp_valid", 40'(bus.resp_valid), 40'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("resp_is_store", 40'(bus.resp_is_store), 40'(h.st));
            check("resp_rdata", 40'(bus.resp_rdata), 40'(h.dat));
            check("resp_id", 40'(bus.resp_id), 40'(h.id));
         end
      end
      acc = v & exp_rdy;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && rd) void'(exp_q.pop_front());
         if (acc) begin
            h.st  = we;
            h.dat = we ? 33'd0 : refmem[a];
            h.id  = id;
            exp_q.push_back(h);
            if (we) refmem[a] = d;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rd);
      logic acc;
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'($urandom), 33'd0, 4'd0, rd, acc);
   endtask

   task automatic send(input logic we, input logic [7:0] a, input logic [32:0] d,
                       input logic [3:0] id, input logic rd);
      logic acc;
      int   n;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
         step(0, 1, we, a, d, id, rd, acc);
         n++;
      end
      check("send_accepted", 40'(acc), 40'(1));
   endtask

   initial begin
      logic acc;
      int   sent;
      int   cyc;
      logic [7:0] a;
      logic [3:0] id;

      tests    = 0;
      fails    = 0;
      mem_init = 1'b1;
      rst      = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_id     = '0;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 256; i++) refmem[i] = pat(i);
      @(negedge clk);

      // Reset state, including a store presented under reset.
      step(1, 0, 0, 8'h00, 33'd0, 4'd0, 1, acc);
      step(1, 1, 1, 8'h05, 33'h1_0000_00FF, 4'd1, 1, acc);
      mem_init = 1'b0;
      idle(1, 1);

      // Store then load of the same word, tag bit set.
      send(1, 8'h10, 33'h1_DEADBEEF, 4'd3, 1);
      send(0, 8'h10, 33'd0, 4'd4, 1);
      idle(2, 1);

      // Preload 0..7 then eight back-to-back loads.
      for (int i = 0; i < 8; i++) send(1, 8'(i), 33'(i), 4'(i), 1);
      for (int i = 0; i < 8; i++) send(0, 8'(i), 33'd0, 4'(i + 8), 1);
      idle(2, 1);

      // Backpressure: third load must be refused while two responses are outstanding.
      step(0, 1, 0, 8'd1, 33'd0, 4'd1, 0, acc);
      step(0, 1, 0, 8'd2, 33'd0, 4'd2, 0, acc);
      step(0, 1, 0, 8'd3, 33'd0, 4'd3, 0, acc);
      check("third_load_refused", 40'(acc), 40'(0));
      idle(3, 0);
      send(0, 8'd3, 33'd0, 4'd3, 1);
      idle(4, 1);

      // resp_ready toggling every cycle under a 16-load stream with random ids.
      sent = 0;
      cyc  = 0;
      a    = 8'($urandom);
      id   = 4'($urandom);
      while (sent < 16 && cyc < 200) begin
         step(0, 1, 0, a, 33'd0, id, cyc[0], acc);
         if (acc) begin
            sent++;
            a  = 8'($urandom);
            id = 4'($urandom);
         end
         cyc++;
      end
      check("toggle_stream_sent", 40'(sent), 40'(16));
      idle(4, 1);

      // Random mix of loads, stores and backpressure.
      for (int i = 0; i < 300; i++) begin
         step(0, 1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)),
              {1'($urandom), 32'($urandom)}, 4'($urandom), 1'($urandom), acc);
      end
      idle(4, 1);

      // Reset with two responses buffered and a store presented.
      step(0, 1, 0, 8'h40, 33'd0, 4'd6, 0, acc);
      step(0, 1, 0, 8'h41, 33'd0, 4'd7, 0, acc);
      step(1, 1, 1, 8'h20, 33'h1_BADC0FFE, 4'd8, 0, acc);
      idle(1, 1);
      send(0, 8'h20, 33'd0, 4'd9, 1);
      idle(2, 1);

      // Tag-0 store over a tag-1 word.
      send(1, 8'h30, 33'h1_FFFFFFFF, 4'd10, 1);
      send(1, 8'h30, 33'h0_12345678, 4'd11, 1);
      send(0, 8'h30, 33'd0, 4'd12, 1);
      idle(1, 1);
      check("tag_cleared_word", 40'(mem[8'h30]), 40'(33'h0_12345678));
      idle(2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Requester side of the single-port synchronous data memory (33-bit words: bit 32 is the tag bit, bits 31:0 are data).
- Accepts load/store requests from the core pipeline over a valid/ready channel and drives the memory port.
- Captures the one-cycle-latency read data and returns in-order responses over a second valid/ready channel, absorbing consumer backpressure.
- Sustains one request per cycle when the consumer is ready.

Parameters:
ADDRESS_WIDTH, 8, word address width; must match the memory port
ID_WIDTH, 4, width of the opaque request identifier returned with each response

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active high
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDRESS_WIDTH  word address
req_wdata  input  33  store data including tag bit 32
req_id  input  ID_WIDTH  identifier echoed in response
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS_WIDTH  memory address
mem_wdata  output  33  memory write data
mem_rdata  input  33  memory read data, valid one cycle after address presented
resp_valid  output  1  response present
resp_ready  input  1  response consumed when resp_valid & resp_ready
resp_is_store  output  1  response belongs to a store
resp_rdata  output  33  load data; all zero for store responses
resp_id  output  ID_WIDTH  echoed req_id

Behaviour:
- Clock is clk; reset is rst, synchronous and active high. One clock domain.
- Issue (combinational):
  - mem_addr = req_addr and mem_wdata = req_wdata at all times.
  - mem_we = req_valid & req_ready & req_we, so no write occurs unless the request is accepted.
- In-flight register:
  - Holds {valid, is_store, id} for the request accepted in the previous cycle.
  - Set on acceptance, cleared otherwise.
  - Reset value: valid = 0.
- Response buffer:
  - 2-entry FIFO of {is_store, rdata, id}; count register, read/write pointers wrap modulo 2.
  - Reset value: count = 0, pointers = 0.
- In-flight data is mem_rdata (forced to 0 if is_store) in the cycle the in-flight valid bit is 1.
- Output selection:
  - FIFO non-empty: outputs come from the FIFO head.
  - FIFO empty and in-flight valid: bypass, resp_* driven directly from the in-flight register and mem_rdata.
  - Otherwise resp_valid = 0.
- In-flight data is pushed into the FIFO when in-flight valid and NOT (bypassed and resp_ready).
  - Push and pop in the same cycle are allowed; count stays unchanged.
- req_ready = !rst & (count + in_flight_valid <= 1), computed from registers only with no combinational path from resp_ready.
  - Guarantees the FIFO never overflows.
- Load latency: request accepted in cycle N → resp_valid in cycle N+1 with mem_rdata from that cycle.
  - Stores also produce a response in N+1; the write lands at the memory edge ending cycle N.
- Ordering: responses are strictly in acceptance order; bypass is never used while the FIFO holds entries.
- Throughput: with resp_ready held 1, req_ready stays 1 and one request completes per cycle.
  - With resp_ready = 0, at most 2 responses are buffered (1 in FIFO + 1 in flight → req_ready = 0, then 2 in FIFO).
- Response stability: while resp_valid & !resp_ready, all resp_* fields hold stable.
  - Bypassed data is pushed to the FIFO so a later change in mem_rdata cannot corrupt it.
- Tag bit 32 passes unmodified in both directions; no interpretation.
- Reset mid-operation:
  - In-flight valid and FIFO are cleared and pending responses are discarded.
  - req_ready = 0 and mem_we = 0 during every rst cycle.
  - resp_valid = 0 in the cycle after rst is sampled high.
- Reset values: resp_valid 0, resp_rdata 0, resp_id 0, resp_is_store 0, req_ready 0 while rst = 1.

Test Plan:
- Store addr 0x10, data 33'h1_DEADBEEF, id 3; then load addr 0x10, id 4; resp_ready = 1 → store resp (is_store 1, rdata 0, id 3) cycle after accept; load resp rdata 33'h1_DEADBEEF, id 4, tag bit set.
- Preload addrs 0..7 with value i; 8 back-to-back loads, resp_ready = 1 → req_ready never drops; 8 responses on consecutive cycles, rdata = 0..7 in order.
- Loads to addrs 1,2,3 back-to-back, resp_ready = 0 → req_ready drops after 2 accepts; resp_* hold addr 1 data stable; resp_ready = 1 → responses 1,2,3 in order, none lost.
- resp_ready toggling every cycle during 16-load stream with random ids → response ids match request order exactly; count never exceeds 2.
- Assert rst while 2 responses are buffered and a store is presented → no memory write in the rst cycle; resp_valid = 0 next cycle; a subsequent load returns pre-reset memory contents.
- Store with tag 0 (33'h0_12345678) over tag-1 word, then load → rdata 33'h0_12345678 (tag cleared).
